// File: rtl/ex_pkg.sv
// Shared encodings for the RV32IM execute stage.
// ALU, branch, RV32M and forward-select codes plus the M-unit state type.
package ex_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_BEQ  = 4'd1;
    localparam logic [3:0] BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BLT  = 4'd3;
    localparam logic [3:0] BR_BGE  = 4'd4;
    localparam logic [3:0] BR_BLTU = 4'd5;
    localparam logic [3:0] BR_BGEU = 4'd6;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_DONE
    } md_state_t;

    typedef struct packed {
        logic       valid;
        logic       reg_we;
        logic       mem_we;
        logic       jalx;
        logic       src1;
        logic       src2;
        logic [3:0] branch;
        logic [3:0] alu_ctr;
        logic       md_en;
        logic [2:0] md_op;
        logic [2:0] op;
        logic [1:0] wb_ctr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ex_ctl_t;

endpackage

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Signed ops run on magnitudes; signs are fixed when the result is read in DONE.
module md_unit
    import ex_pkg::*;
#(
    parameter int W        = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         hold,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] res
);

    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    md_state_t state, state_n;
    logic [W-1:0] hi, lo, m, hi_n, lo_n, m_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] op_q, op_n;
    logic neg, neg_n, direct, direct_n;

    logic sa, sb, a_neg, b_neg;
    logic [W-1:0] am, bm, div_diff, res_i;
    logic [W:0] mul_sum, div_sh;
    logic div_ge;
    logic [2*W-1:0] fprod, prod, prod_s;

    always_comb begin
        sa = (op == MD_MULH) | (op == MD_MULHSU) | (op == MD_DIV) | (op == MD_REM);
        sb = (op == MD_MULH) | (op == MD_DIV) | (op == MD_REM);
        a_neg = sa & a[W-1];
        b_neg = sb & b[W-1];
        am = a_neg ? -a : a;
        bm = b_neg ? -b : b;
        fprod = {{W{a_neg}}, a} * {{W{b_neg}}, b};
    end

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        div_sh = {hi, lo[W-1]};
        div_ge = div_sh >= {1'b0, m};
        div_diff = div_sh[W-1:0] - m;
        prod = {hi, lo};
        prod_s = neg ? -prod : prod;
        res_i = prod_s[2*W-1:W];
        case (op_q)
            MD_MUL:          res_i = prod_s[W-1:0];
            MD_DIV, MD_DIVU: res_i = neg ? -lo : lo;
            MD_REM, MD_REMU: res_i = neg ? -hi : hi;
            default: ;
        endcase
        res = direct ? lo : res_i;
    end

    assign busy = (state == MD_RUN) | ((state == MD_IDLE) & start);
    assign done = (state == MD_DONE);

    always_comb begin
        state_n  = state;
        hi_n     = hi;
        lo_n     = lo;
        m_n      = m;
        cnt_n    = cnt;
        op_n     = op_q;
        neg_n    = neg;
        direct_n = direct;
        if (abort) begin
            state_n = MD_IDLE;
        end else begin
            case (state)
                MD_IDLE: if (start) begin
                    op_n     = op;
                    hi_n     = '0;
                    cnt_n    = '0;
                    direct_n = 1'b0;
                    state_n  = MD_RUN;
                    m_n      = op[2] ? bm : am;
                    lo_n     = op[2] ? am : bm;
                    neg_n    = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
                    // Cases with a closed-form answer skip the iteration
                    if (op[2] && b == '0) begin
                        direct_n = 1'b1;
                        lo_n     = op[1] ? a : '1;
                        state_n  = MD_DONE;
                    end else if (op[2] && sa && a == MIN && b == '1) begin
                        direct_n = 1'b1;
                        lo_n     = op[1] ? '0 : MIN;
                        state_n  = MD_DONE;
                    end else if (FAST_MUL && !op[2]) begin
                        direct_n = 1'b1;
                        lo_n     = (op == MD_MUL) ? fprod[W-1:0] : fprod[2*W-1:W];
                        state_n  = MD_DONE;
                    end
                end
                MD_RUN: begin
                    cnt_n = cnt + 1'b1;
                    if (op_q[2]) begin
                        hi_n = div_ge ? div_diff : div_sh[W-1:0];
                        lo_n = {lo[W-2:0], div_ge};
                    end else begin
                        {hi_n, lo_n} = {mul_sum, lo[W-1:1]};
                    end
                    if (cnt == CW'(W - 1)) state_n = MD_DONE;
                end
                MD_DONE: if (!hold) state_n = MD_IDLE;
                default: state_n = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= MD_IDLE;
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
            cnt    <= '0;
            op_q   <= '0;
            neg    <= 1'b0;
            direct <= 1'b0;
        end else begin
            state  <= state_n;
            hi     <= hi_n;
            lo     <= lo_n;
            m      <= m_n;
            cnt    <= cnt_n;
            op_q   <= op_n;
            neg    <= neg_n;
            direct <= direct_n;
        end
    end

endmodule

// File: rtl/ex_stage_md.sv
// EX stage: ID/EX register, forwarding, ALU, branch resolve and the M unit.
// ex_busy holds IF/ID/EX while a multiply/divide is in flight.
module ex_stage_md
    import ex_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter bit FAST_MUL   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_d,
    input  logic                  reg_we,
    input  logic                  mem_we,
    input  logic                  jalx,
    input  logic                  alu_src_1_ctr,
    input  logic                  alu_src_2_ctr,
    input  logic [3:0]            branch,
    input  logic [3:0]            alu_ctr,
    input  logic                  md_en,
    input  logic [2:0]            md_op,
    input  logic [2:0]            op,
    input  logic [1:0]            wb_ctr,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [DATA_WIDTH-1:0] rd1,
    input  logic [DATA_WIDTH-1:0] rd2,
    input  logic [ADDR_WIDTH-1:0] pcd,
    input  logic [ADDR_WIDTH-1:0] pcnd,
    input  logic [DATA_WIDTH-1:0] alu_resultm,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic [1:0]            rd1_ctr,
    input  logic [1:0]            rd2_ctr,
    input  logic                  stall_e,
    input  logic                  flush_e,
    output logic                  valid_e,
    output logic                  reg_wee,
    output logic                  mem_wee,
    output logic [2:0]            ope,
    output logic [1:0]            wb_ctre,
    output logic [4:0]            rde,
    output logic [4:0]            rs1e,
    output logic [4:0]            rs2e,
    output logic [ADDR_WIDTH-1:0] pcne,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic [DATA_WIDTH-1:0] rd2_true,
    output logic                  taken,
    output logic                  ex_busy
);

    localparam int SHW = $clog2(DATA_WIDTH);

    ex_ctl_t ctl_d, ctl_e;
    logic [DATA_WIDTH-1:0] imm_e, rd1_e, rd2_e;
    logic [ADDR_WIDTH-1:0] pc_e, pcn_e;
    logic [DATA_WIDTH-1:0] rd1_true, src_a, src_b, alu_out, md_res;
    logic [SHW-1:0] shamt;
    logic cond, md_busy, md_done;

    always_comb begin
        ctl_d = '{valid: valid_d, reg_we: reg_we, mem_we: mem_we,
                  jalx: jalx, src1: alu_src_1_ctr, src2: alu_src_2_ctr,
                  branch: branch, alu_ctr: alu_ctr, md_en: md_en,
                  md_op: md_op, op: op, wb_ctr: wb_ctr,
                  rd: rd, rs1: rs1, rs2: rs2};
    end

    // A flush wins over a hold so a squashed M op cannot keep the stage busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_e <= '0;
            imm_e <= '0;
            rd1_e <= '0;
            rd2_e <= '0;
            pc_e  <= '0;
            pcn_e <= '0;
        end else if (flush_e) begin
            ctl_e <= '0;
            imm_e <= '0;
            rd1_e <= '0;
            rd2_e <= '0;
            pc_e  <= '0;
            pcn_e <= '0;
        end else if (!(stall_e || ex_busy)) begin
            ctl_e <= ctl_d;
            imm_e <= imm;
            rd1_e <= rd1;
            rd2_e <= rd2;
            pc_e  <= pcd;
            pcn_e <= pcnd;
        end
    end

    always_comb begin
        case (rd1_ctr)
            FWD_MEM: rd1_true = alu_resultm;
            FWD_WB:  rd1_true = result;
            default: rd1_true = rd1_e;
        endcase
        case (rd2_ctr)
            FWD_MEM: rd2_true = alu_resultm;
            FWD_WB:  rd2_true = result;
            default: rd2_true = rd2_e;
        endcase
    end

    assign src_a = ctl_e.src1 ? DATA_WIDTH'(pc_e) : rd1_true;
    assign src_b = ctl_e.src2 ? imm_e : rd2_true;
    assign shamt = src_b[SHW-1:0];

    always_comb begin
        alu_out = src_a + src_b;
        case (ctl_e.alu_ctr)
            ALU_SUB:  alu_out = src_a - src_b;
            ALU_SLL:  alu_out = src_a << shamt;
            ALU_SLT:  alu_out = DATA_WIDTH'($signed(src_a) < $signed(src_b));
            ALU_SLTU: alu_out = DATA_WIDTH'(src_a < src_b);
            ALU_XOR:  alu_out = src_a ^ src_b;
            ALU_SRL:  alu_out = src_a >> shamt;
            ALU_SRA:  alu_out = $signed(src_a) >>> shamt;
            ALU_OR:   alu_out = src_a | src_b;
            ALU_AND:  alu_out = src_a & src_b;
            ALU_LUI:  alu_out = src_b;
            default: ;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (ctl_e.branch)
            BR_BEQ:  cond = rd1_true == rd2_true;
            BR_BNE:  cond = rd1_true != rd2_true;
            BR_BLT:  cond = $signed(rd1_true) < $signed(rd2_true);
            BR_BGE:  cond = $signed(rd1_true) >= $signed(rd2_true);
            BR_BLTU: cond = rd1_true < rd2_true;
            BR_BGEU: cond = rd1_true >= rd2_true;
            default: cond = 1'b0;
        endcase
    end

    md_unit #(
        .W        (DATA_WIDTH),
        .FAST_MUL (FAST_MUL)
    ) u_md (
        .clk   (clk),
        .rst   (rst),
        .start (ctl_e.valid & ctl_e.md_en),
        .abort (flush_e),
        .hold  (stall_e),
        .op    (ctl_e.md_op),
        .a     (rd1_true),
        .b     (rd2_true),
        .busy  (md_busy),
        .done  (md_done),
        .res   (md_res)
    );

    assign ex_busy    = md_busy;
    assign alu_result = md_done ? md_res : alu_out;
    assign taken      = ctl_e.valid & (ctl_e.jalx | cond);
    assign valid_e    = ctl_e.valid;
    assign reg_wee    = ctl_e.valid & ctl_e.reg_we;
    assign mem_wee    = ctl_e.valid & ctl_e.mem_we;
    assign ope        = ctl_e.op;
    assign wb_ctre    = ctl_e.wb_ctr;
    assign rde        = ctl_e.rd;
    assign rs1e       = ctl_e.rs1;
    assign rs2e       = ctl_e.rs2;
    assign pcne       = pcn_e;

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md with a result/latency scoreboard.
// Expected values come from constants or a 64-bit reference model.
module tb_ex_stage_md;
    import ex_pkg::*;

    localparam int IT = 33;

    typedef struct packed {
        logic [31:0] res;
        logic [7:0]  busy;
        logic        taken;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic valid_d, reg_we, mem_we, jalx, alu_src_1_ctr, alu_src_2_ctr;
    logic [3:0] branch, alu_ctr;
    logic md_en;
    logic [2:0] md_op, op;
    logic [1:0] wb_ctr;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm, rd1, rd2, pcd, pcnd, alu_resultm, result;
    logic [1:0] rd1_ctr, rd2_ctr;
    logic stall_e, flush_e;
    logic valid_e, reg_wee, mem_wee;
    logic [2:0] ope;
    logic [1:0] wb_ctre;
    logic [4:0] rde, rs1e, rs2e;
    logic [31:0] pcne, alu_result, rd2_true;
    logic taken, ex_busy;

    int total = 0;
    int bad = 0;
    exp_t sb[$];

    ex_stage_md dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .reg_we(reg_we),
        .mem_we(mem_we), .jalx(jalx), .alu_src_1_ctr(alu_src_1_ctr),
        .alu_src_2_ctr(alu_src_2_ctr), .branch(branch), .alu_ctr(alu_ctr),
        .md_en(md_en), .md_op(md_op), .op(op), .wb_ctr(wb_ctr),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .rd1(rd1), .rd2(rd2),
        .pcd(pcd), .pcnd(pcnd), .alu_resultm(alu_resultm), .result(result),
        .rd1_ctr(rd1_ctr), .rd2_ctr(rd2_ctr), .stall_e(stall_e),
        .flush_e(flush_e), .valid_e(valid_e), .reg_wee(reg_wee),
        .mem_wee(mem_wee), .ope(ope), .wb_ctre(wb_ctre), .rde(rde),
        .rs1e(rs1e), .rs2e(rs2e), .pcne(pcne), .alu_result(alu_result),
        .rd2_true(rd2_true), .taken(taken), .ex_busy(ex_busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] r, input int bz, input logic t);
        exp_t e;
        e.res = r;
        e.busy = 8'(bz);
        e.taken = t;
        return e;
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb2;
        longint unsigned ua, ub;
        logic [63:0] p;
        logic ovf;
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p = '0;
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb2; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: if (b == 0) return 32'hFFFF_FFFF;
                  else if (ovf) return a;
                  else return 32'($signed(a) / $signed(b));
            3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
            3'd6: if (b == 0) return a;
                  else if (ovf) return 32'h0;
                  else return 32'($signed(a) % $signed(b));
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
        if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return IT;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        valid_d = 0; reg_we = 0; md_en = 0; branch = BR_NONE;
        rd1 = $urandom; rd2 = $urandom;
    endtask

    task automatic exec(input string tag, input logic [3:0] alu, input logic [3:0] br,
                        input logic md, input logic [2:0] mop, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] f1,
                        input int stall_n, input exp_t e);
        int n;
        exp_t got;
        @(negedge clk);
        valid_d = 1; reg_we = 1; alu_ctr = alu; branch = br;
        md_en = md; md_op = mop;
        rd1 = (f1 == FWD_MEM) ? ~a : a;
        alu_resultm = a; rd1_ctr = f1;
        rd2 = b; rd2_ctr = FWD_RF;
        sb.push_back(e);
        @(posedge clk);
        #1 bubble();
        n = 0;
        @(negedge clk);
        while (ex_busy && n < 200) begin
            n++;
            if (n == 2) begin
                alu_resultm = $urandom;
                result = $urandom;
            end
            @(negedge clk);
        end
        got = sb.pop_front();
        chk({tag, ".res"}, alu_result, got.res);
        chk({tag, ".busy"}, 32'(n), 32'(got.busy));
        chk({tag, ".taken"}, 32'(taken), 32'(got.taken));
        if (stall_n > 0) begin
            stall_e = 1;
            for (int k = 0; k < stall_n; k++) begin
                @(negedge clk);
                chk({tag, ".hold"}, alu_result, got.res);
                chk({tag, ".hold_busy"}, 32'(ex_busy), 32'h0);
            end
            stall_e = 0;
        end
    endtask

    initial begin
        rst = 0;
        valid_d = 0; reg_we = 0; mem_we = 0; jalx = 0;
        alu_src_1_ctr = 0; alu_src_2_ctr = 0;
        branch = 0; alu_ctr = 0; md_en = 0; md_op = 0; op = 0; wb_ctr = 0;
        rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = 0; rd1 = 0; rd2 = 0;
        pcd = 32'h100; pcnd = 32'h104; alu_resultm = 0; result = 0;
        rd1_ctr = 0; rd2_ctr = 0; stall_e = 0; flush_e = 0;

        repeat (2) @(negedge clk);
        chk("rst.valid_e", 32'(valid_e), 32'h0);
        chk("rst.reg_wee", 32'(reg_wee), 32'h0);
        chk("rst.taken", 32'(taken), 32'h0);
        chk("rst.ex_busy", 32'(ex_busy), 32'h0);
        chk("rst.alu_result", alu_result, 32'h0);
        rst = 1;

        exec("add_fwd", ALU_ADD, BR_NONE, 0, 0, 32'h10, 32'h5, FWD_MEM, 0,
             mk(32'h15, 0, 0));
        exec("beq", ALU_ADD, BR_BEQ, 0, 0, 32'h33, 32'h33, FWD_MEM, 0,
             mk(32'h66, 0, 1));
        exec("blt", ALU_ADD, BR_BLT, 0, 0, 32'hFFFF_FFFF, 32'h1, FWD_RF, 0,
             mk(32'h0, 0, 1));
        exec("bltu", ALU_ADD, BR_BLTU, 0, 0, 32'hFFFF_FFFF, 32'h1, FWD_RF, 0,
             mk(32'h0, 0, 0));
        exec("sra", ALU_SRA, BR_NONE, 0, 0, 32'hFFFF_FF00, 32'h4, FWD_RF, 0,
             mk(32'hFFFF_FFF0, 0, 0));

        exec("divu", ALU_ADD, BR_NONE, 1, MD_DIVU, 32'd100, 32'd7, FWD_MEM, 0,
             mk(32'd14, IT, 0));
        exec("remu", ALU_ADD, BR_NONE, 1, MD_REMU, 32'd100, 32'd7, FWD_RF, 0,
             mk(32'd2, IT, 0));

        exec("div_ovf", ALU_ADD, BR_NONE, 1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
             FWD_RF, 0, mk(32'h8000_0000, 1, 0));
        exec("rem_ovf", ALU_ADD, BR_NONE, 1, MD_REM, 32'h8000_0000, 32'hFFFF_FFFF,
             FWD_RF, 0, mk(32'h0, 1, 0));
        exec("div_z", ALU_ADD, BR_NONE, 1, MD_DIV, 32'd9, 32'd0, FWD_RF, 0,
             mk(32'hFFFF_FFFF, 1, 0));
        exec("rem_z", ALU_ADD, BR_NONE, 1, MD_REM, 32'd9, 32'd0, FWD_RF, 0,
             mk(32'd9, 1, 0));

        exec("mul", ALU_ADD, BR_NONE, 1, MD_MUL, 32'hFFFF_FFFD, 32'd5, FWD_RF, 3,
             mk(32'hFFFF_FFF1, IT, 0));
        exec("mulh", ALU_ADD, BR_NONE, 1, MD_MULH, 32'hFFFF_FFFD, 32'd5, FWD_RF, 0,
             mk(32'hFFFF_FFFF, IT, 0));
        exec("mulhu", ALU_ADD, BR_NONE, 1, MD_MULHU, 32'hFFFF_FFFF, 32'd2, FWD_RF, 0,
             mk(32'h1, IT, 0));

        @(negedge clk);
        valid_d = 1; reg_we = 1; alu_ctr = ALU_ADD; md_en = 1; md_op = MD_DIVU;
        rd1 = 32'd100; rd2 = 32'd7; rd1_ctr = FWD_RF; rd2_ctr = FWD_RF;
        @(posedge clk);
        #1 bubble();
        for (int k = 0; k < 6; k++) @(negedge clk);
        flush_e = 1;
        @(posedge clk);
        #1 flush_e = 0;
        chk("flush.valid_e", 32'(valid_e), 32'h0);
        chk("flush.reg_wee", 32'(reg_wee), 32'h0);
        chk("flush.ex_busy", 32'(ex_busy), 32'h0);
        exec("add_after_flush", ALU_ADD, BR_NONE, 0, 0, 32'd7, 32'd8, FWD_RF, 0,
             mk(32'd15, 0, 0));

        @(negedge clk);
        valid_d = 1; reg_we = 1; alu_ctr = ALU_ADD; md_en = 1; md_op = MD_DIVU;
        rd1 = 32'd100; rd2 = 32'd7;
        @(posedge clk);
        #1 bubble();
        for (int k = 0; k < 10; k++) @(negedge clk);
        #2 rst = 0;
        #1;
        chk("arst.valid_e", 32'(valid_e), 32'h0);
        chk("arst.ex_busy", 32'(ex_busy), 32'h0);
        @(negedge clk);
        rst = 1;
        exec("add_after_rst", ALU_ADD, BR_NONE, 0, 0, 32'd20, 32'd22, FWD_RF, 0,
             mk(32'd42, 0, 0));

        for (int i = 0; i < 6; i++) begin
            logic [2:0] o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i == 0) ? 32'd0 : ((i == 1) ? 32'($urandom_range(1, 50)) : $urandom);
            exec("rand_md", ALU_ADD, BR_NONE, 1, o, a, b, FWD_RF, 0,
                 mk(ref_md(o, a, b), exp_busy(o, a, b), 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
